// File: rtl/pushbutton_pkg.sv
// Shared types and default timing constants for the pushbutton bank.
// 100 MHz clock assumed for the default cycle counts.
package pushbutton_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PRESSED = 2'd1,
      HELD    = 2'd2
   } btn_state_t;

   localparam int DEF_N_CH          = 5;
   localparam int DEF_DEB_CYCLES    = 1_000_000;
   localparam int DEF_HOLD_CYCLES   = 50_000_000;
   localparam int DEF_REPEAT_CYCLES = 10_000_000;
   localparam int DEF_REPEAT_EN     = 1;

endpackage

// File: rtl/pushbutton_channel.sv
// One button channel: synchronizer, debounce, press/hold/repeat FSM.
// All outputs are registered.
module pushbutton_channel
   import pushbutton_pkg::*;
#(
   parameter int DEB_CYCLES    = DEF_DEB_CYCLES,
   parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
   parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES,
   parameter int REPEAT_EN     = DEF_REPEAT_EN
) (
   input  logic clk,
   input  logic rst,
   input  logic btn,
   output logic level,
   output logic pressed,
   output logic released,
   output logic hold
);

   localparam int DW = $clog2(DEB_CYCLES + 1);
   localparam int HW = $clog2(HOLD_CYCLES + 1);
   localparam int RW = $clog2(REPEAT_CYCLES + 1);

   logic [1:0]    sync;
   logic [DW-1:0] deb_cnt;
   logic [HW-1:0] hold_cnt, hold_cnt_nx;
   logic [RW-1:0] rep_cnt, rep_cnt_nx;
   btn_state_t    state, state_nx;
   logic          toggle, rise, fall;
   logic          pressed_nx, released_nx, hold_nx;

   assign toggle = (sync[1] != level) && (deb_cnt == DW'(DEB_CYCLES));
   assign rise   = toggle && !level;
   assign fall   = toggle && level;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync     <= '0;
         deb_cnt  <= '0;
         level    <= 1'b0;
         state    <= IDLE;
         hold_cnt <= '0;
         rep_cnt  <= '0;
         pressed  <= 1'b0;
         released <= 1'b0;
         hold     <= 1'b0;
      end else begin
         sync <= {sync[0], btn};
         if (sync[1] == level) begin
            deb_cnt <= '0;
         end else if (toggle) begin
            deb_cnt <= '0;
            level   <= ~level;
         end else if (deb_cnt != DW'(DEB_CYCLES)) begin
            deb_cnt <= deb_cnt + 1'b1;
         end
         state    <= state_nx;
         hold_cnt <= hold_cnt_nx;
         rep_cnt  <= rep_cnt_nx;
         pressed  <= pressed_nx;
         released <= released_nx;
         hold     <= hold_nx;
      end
   end

   // A debounced fall always wins over a pending hold or repeat event.
   always_comb begin
      state_nx    = state;
      hold_cnt_nx = hold_cnt;
      rep_cnt_nx  = rep_cnt;
      pressed_nx  = 1'b0;
      released_nx = 1'b0;
      hold_nx     = hold;
      unique case (state)
         IDLE: begin
            if (rise) begin
               state_nx    = PRESSED;
               hold_cnt_nx = '0;
               pressed_nx  = 1'b1;
            end
         end
         PRESSED: begin
            if (fall) begin
               state_nx    = IDLE;
               released_nx = 1'b1;
               hold_nx     = 1'b0;
               hold_cnt_nx = '0;
               rep_cnt_nx  = '0;
            end else if (hold_cnt == HW'(HOLD_CYCLES - 1)) begin
               state_nx   = HELD;
               hold_nx    = 1'b1;
               rep_cnt_nx = '0;
               pressed_nx = (REPEAT_EN != 0);
            end else if (hold_cnt != HW'(HOLD_CYCLES)) begin
               hold_cnt_nx = hold_cnt + 1'b1;
            end
         end
         HELD: begin
            if (fall) begin
               state_nx    = IDLE;
               released_nx = 1'b1;
               hold_nx     = 1'b0;
               hold_cnt_nx = '0;
               rep_cnt_nx  = '0;
            end else if ((REPEAT_EN != 0) &&
                         (rep_cnt == RW'(REPEAT_CYCLES - 1))) begin
               pressed_nx = 1'b1;
               rep_cnt_nx = '0;
            end else if (rep_cnt != RW'(REPEAT_CYCLES)) begin
               rep_cnt_nx = rep_cnt + 1'b1;
            end
         end
         default: begin
            state_nx = IDLE;
            hold_nx  = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/pushbutton_bank.sv
// Bank of N_CH independent debounced pushbutton channels.
// Pure wiring around pushbutton_channel.
module pushbutton_bank
   import pushbutton_pkg::*;
#(
   parameter int N_CH          = DEF_N_CH,
   parameter int DEB_CYCLES    = DEF_DEB_CYCLES,
   parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
   parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES,
   parameter int REPEAT_EN     = DEF_REPEAT_EN
) (
   input  logic            clk_100Mhz,
   input  logic            rst,
   input  logic [N_CH-1:0] btn_in,
   output logic [N_CH-1:0] level,
   output logic [N_CH-1:0] pressed,
   output logic [N_CH-1:0] released,
   output logic [N_CH-1:0] hold
);

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      pushbutton_channel #(
         .DEB_CYCLES    (DEB_CYCLES),
         .HOLD_CYCLES   (HOLD_CYCLES),
         .REPEAT_CYCLES (REPEAT_CYCLES),
         .REPEAT_EN     (REPEAT_EN)
      ) u_ch (
         .clk      (clk_100Mhz),
         .rst      (rst),
         .btn      (btn_in[i]),
         .level    (level[i]),
         .pressed  (pressed[i]),
         .released (released[i]),
         .hold     (hold[i])
      );
   end

endmodule

// File: tb/tb_pushbutton_bank.sv
// Directed bench for pushbutton_bank: table vectors plus hold,
// repeat and reset sequences, with and without auto-repeat.
module tb_pushbutton_bank;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] btn, btn2;
   logic [4:0] lvl, prs, rel, hld;
   logic [4:0] lvl2, prs2, rel2, hld2;
   int         checks = 0;
   int         errors = 0;

   always #5 clk = ~clk;

   pushbutton_bank #(
      .N_CH(5), .DEB_CYCLES(4), .HOLD_CYCLES(20),
      .REPEAT_CYCLES(5), .REPEAT_EN(1)
   ) dut (
      .clk_100Mhz(clk), .rst(rst), .btn_in(btn),
      .level(lvl), .pressed(prs), .released(rel), .hold(hld)
   );

   pushbutton_bank #(
      .N_CH(5), .DEB_CYCLES(4), .HOLD_CYCLES(20),
      .REPEAT_CYCLES(5), .REPEAT_EN(0)
   ) dut2 (
      .clk_100Mhz(clk), .rst(rst), .btn_in(btn2),
      .level(lvl2), .pressed(prs2), .released(rel2), .hold(hld2)
   );

   typedef struct {
      logic [4:0] b;
      logic [4:0] l;
      logic [4:0] p;
      logic [4:0] r;
      logic [4:0] h;
   } vec_t;

   vec_t tbl[20];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input int e,
                      input logic [4:0] act, input logic [4:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s edge %0d: got %b expected %b",
                  name, e, act, exp);
      end
   endtask

   initial begin
      // ch0, ch3, ch4 press; ch1 glitches for 3 cycles; then all release
      for (int i = 0; i < 3; i++)
         tbl[i] = '{5'b11011, 5'b00000, 5'b00000, 5'b00000, 5'b00000};
      for (int i = 3; i < 6; i++)
         tbl[i] = '{5'b11001, 5'b00000, 5'b00000, 5'b00000, 5'b00000};
      tbl[6] = '{5'b11001, 5'b11001, 5'b11001, 5'b00000, 5'b00000};
      for (int i = 7; i < 10; i++)
         tbl[i] = '{5'b11001, 5'b11001, 5'b00000, 5'b00000, 5'b00000};
      for (int i = 10; i < 16; i++)
         tbl[i] = '{5'b00000, 5'b11001, 5'b00000, 5'b00000, 5'b00000};
      tbl[16] = '{5'b00000, 5'b00000, 5'b00000, 5'b11001, 5'b00000};
      for (int i = 17; i < 20; i++)
         tbl[i] = '{5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000};

      rst  = 1'b1;
      btn  = '0;
      btn2 = '0;
      tick();
      tick();
      chk("rst_level", -1, lvl, 5'b0);
      chk("rst_pressed", -1, prs, 5'b0);
      chk("rst_released", -1, rel, 5'b0);
      chk("rst_hold", -1, hld, 5'b0);
      rst = 1'b0;
      tick();

      for (int e = 0; e < 20; e++) begin
         btn = tbl[e].b;
         tick();
         chk("tbl_level", e, lvl, tbl[e].l);
         chk("tbl_pressed", e, prs, tbl[e].p);
         chk("tbl_released", e, rel, tbl[e].r);
         chk("tbl_hold", e, hld, tbl[e].h);
      end

      // ch2 held, release lands on a would-be repeat edge (46)
      for (int e = 0; e < 52; e++) begin
         logic       on;
         logic [4:0] ep, eh, er, ep2;
         on   = (e < 40);
         btn  = {2'b00, on, 2'b00};
         btn2 = {2'b00, on, 2'b00};
         tick();
         ep  = (e == 6 || e == 26 || e == 31 || e == 36 || e == 41)
               ? 5'b00100 : 5'b0;
         ep2 = (e == 6) ? 5'b00100 : 5'b0;
         eh  = (e >= 26 && e < 46) ? 5'b00100 : 5'b0;
         er  = (e == 46) ? 5'b00100 : 5'b0;
         chk("hold_pressed", e, prs, ep);
         chk("hold_hold", e, hld, eh);
         chk("hold_released", e, rel, er);
         chk("norep_pressed", e, prs2, ep2);
         chk("norep_hold", e, hld2, eh);
         chk("norep_released", e, rel2, er);
      end

      // reset while ch0 is in hold, button kept down
      btn  = 5'b00001;
      btn2 = '0;
      for (int e = 0; e < 30; e++) tick();
      chk("pre_rst_hold", 29, hld, 5'b00001);
      rst = 1'b1;
      tick();
      chk("mid_rst_level", 0, lvl, 5'b0);
      chk("mid_rst_pressed", 0, prs, 5'b0);
      chk("mid_rst_released", 0, rel, 5'b0);
      chk("mid_rst_hold", 0, hld, 5'b0);
      rst = 1'b0;
      for (int e = 0; e < 10; e++) begin
         tick();
         chk("post_rst_pressed", e, prs,
             (e == 6) ? 5'b00001 : 5'b0);
         chk("post_rst_released", e, rel, 5'b0);
         chk("post_rst_level", e, lvl,
             (e >= 6) ? 5'b00001 : 5'b0);
      end

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule

// File: doc/pushbutton_bank.md
PUSHBUTTON_BANK -- requirements
Module: pushbutton_bank

Interface
REQ-001 The block SHALL take parameter N_CH, default 5, as the number of independent button channels (range 1..32).
REQ-002 The block SHALL take parameter DEB_CYCLES, default 1_000_000 (10 ms at 100 MHz), as the stable-input cycles required to change the debounced level (range 1 or more).
REQ-003 The block SHALL take parameter HOLD_CYCLES, default 50_000_000, as the cycles from debounced press to hold assertion (range 1 or more).
REQ-004 The block SHALL take parameter REPEAT_CYCLES, default 10_000_000, as the auto-repeat period while held (range 1 or more).
REQ-005 The block SHALL take parameter REPEAT_EN, default 1, where 1 enables auto-repeat press pulses.
REQ-006 Port clk_100Mhz SHALL be an input, 1 bit wide: the single clock; all logic is on its rising edge.
REQ-007 Port rst SHALL be an input, 1 bit wide: reset, synchronous and active-high.
REQ-008 Port btn_in SHALL be an input, N_CH bits wide: raw asynchronous button inputs, active-high.
REQ-009 Port level SHALL be an output, N_CH bits wide: the debounced button level.
REQ-010 Port pressed SHALL be an output, N_CH bits wide: a one-cycle pulse on each debounced press and on each auto-repeat.
REQ-011 Port released SHALL be an output, N_CH bits wide: a one-cycle pulse on each debounced release.
REQ-012 Port hold SHALL be an output, N_CH bits wide: high while a press has lasted at least HOLD_CYCLES.

Function
REQ-013 Each btn_in bit SHALL pass through a 2-flop synchronizer before any other logic.
REQ-014 Each channel SHALL run a debounce counter that clears whenever the synchronized input equals level[i], and increments otherwise.
REQ-015 When the debounce counter reaches DEB_CYCLES, level[i] SHALL toggle and the counter SHALL clear in the same edge.
REQ-016 For a clean input step, level[i] SHALL change exactly 2+DEB_CYCLES rising edges after the first edge that samples the new btn_in value.
REQ-017 Any input glitch shorter than DEB_CYCLES synchronized cycles SHALL produce no change on any output.
REQ-018 pressed[i] SHALL be asserted for exactly one cycle, registered concurrently with the rising of level[i].
REQ-019 released[i] SHALL be asserted for exactly one cycle, concurrently with the falling of level[i].
REQ-020 Each channel SHALL run an FSM with states IDLE, PRESSED and HELD.
REQ-021 FSM transition IDLE->PRESSED SHALL occur on the level rise, which also clears the hold counter.
REQ-022 FSM transition PRESSED->HELD SHALL occur when the hold counter reaches HOLD_CYCLES-1, i.e. HOLD_CYCLES cycles after the level rise; hold[i] SHALL assert on this same edge.
REQ-023 On the PRESSED->HELD transition, if REPEAT_EN=1, pressed[i] SHALL also pulse on the same edge.
REQ-024 In HELD with REPEAT_EN=1, pressed[i] SHALL pulse every REPEAT_CYCLES cycles after the previous pulse.
REQ-025 In HELD with REPEAT_EN=0, no further pressed pulses SHALL occur.
REQ-026 PRESSED->IDLE and HELD->IDLE SHALL occur on the level fall; on that edge hold[i] SHALL deassert, released[i] SHALL pulse, and the hold and repeat counters SHALL clear.
REQ-027 A release coinciding with a repeat pulse SHALL take priority: released[i] is emitted and no pressed pulse is emitted.
REQ-028 Channels SHALL be fully independent; simultaneous events on multiple channels SHALL all be reported in the same cycle.
REQ-029 Counter widths SHALL be $clog2(max parameter value + 1), and counters SHALL saturate and never wrap.

Reset
REQ-030 While rst=1 at a rising edge, the synchronizers, counters, level, pressed, released and hold SHALL all become 0, and every FSM SHALL return to IDLE.
REQ-031 Reset asserted mid-press SHALL emit no released pulse.
REQ-032 A button still held when rst deasserts SHALL be reported as a fresh press 2+DEB_CYCLES edges after the first edge with rst=0.

Structure
REQ-033 Package pushbutton_pkg SHALL hold the FSM state enum (IDLE, PRESSED, HELD) and the default parameter constants.
REQ-034 Sub-module pushbutton_channel SHALL implement one channel (synchronizer, debounce, FSM, counters), instantiated N_CH times through a generate loop; the top level SHALL contain only wiring.

Verification
REQ-035 The bench SHALL use DEB_CYCLES=4, HOLD_CYCLES=20, REPEAT_CYCLES=5 and N_CH=5.
REQ-036 Clean press test: btn_in[0] high at edge 0 -> level[0]=1 and a one-cycle pressed[0] at edge 6; all other channels stay 0.
REQ-037 Glitch rejection test: btn_in[1] high for 3 cycles then low -> level, pressed and released on channel 1 remain 0 throughout.
REQ-038 Hold/repeat test: btn_in[2] held for 40 cycles after level rise at edge 6 -> hold[2] and pressed[2] at edge 26, pressed[2] at edges 31, 36 and 41; release -> released[2] and hold[2]=0 on the same edge.
REQ-039 Multi-channel test: btn_in[4:3] both rise at edge 0 -> pressed[3] and pressed[4] both pulse at edge 6.
REQ-040 Reset-mid-hold test: rst pulsed while hold[0]=1 and btn_in[0] kept high -> all outputs 0 with no released pulse, then pressed[0] 6 edges after rst falls.
REQ-041 REPEAT_EN=0 test: 40-cycle hold -> exactly one pressed pulse, hold asserts at edge 26, and no further pressed pulses.
